// File: rtl/rx_mii_udp_if.sv
// rx_mii_udp_if: payload byte stream and per-frame status
// produced by the MII/UDP receiver.
interface rx_mii_udp_if;
    logic [7:0]  dout;
    logic        dout_en;
    logic        dout_first;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic        rx_ok;
    logic        rx_err;

    modport master (
        output dout, dout_en, dout_first,
        output src_ip, src_port, rx_ok, rx_err
    );

    modport slave (
        input dout, dout_en, dout_first,
        input src_ip, src_port, rx_ok, rx_err
    );
endinterface

// File: rtl/rx_mii_udp.sv
// rx_mii_udp: MII nibble receiver with Ethernet/IPv4/UDP filtering,
// CRC-32 check and UDP payload streaming.
module rx_mii_udp #(
    parameter int MAX_PAYLOAD  = 512,
    parameter bit ACCEPT_BCAST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   mii_rxd,
    input  logic         mii_rxdv,
    input  logic         mii_rxer,
    input  logic [47:0]  local_mac,
    input  logic [31:0]  local_ip,
    input  logic [15:0]  local_port,
    rx_mii_udp_if.master rx
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_TAIL = 3'd4;
    localparam logic [2:0] S_END  = 3'd5;
    localparam logic [2:0] S_DROP = 3'd6;

    localparam logic [15:0] LEN_MAX = 16'(MAX_PAYLOAD + 8);
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;

    logic [2:0]  state;
    logic [1:0]  pre_cnt;
    logic        phase;
    logic [3:0]  lo_nib;
    logic [5:0]  byte_cnt;
    logic [31:0] crc;
    logic        ucast_ok;
    logic        bcast_ok;
    logic [31:0] sh_ip;
    logic [15:0] sh_port;
    logic [7:0]  len_hi;
    logic [10:0] pay_left;
    logic        first;
    logic        err;

    logic        in_frame;
    logic        byte_stb;
    logic [7:0]  rx_byte;
    logic [15:0] len_now;
    logic [31:0] crc_nxt;
    logic [31:0] crc_rev;
    logic [7:0]  mac_b;
    logic [7:0]  ip_b;
    logic [7:0]  port_b;
    logic        u_ok_n;
    logic        b_ok_n;
    logic        hdr_bad;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign in_frame = (state == S_HDR) || (state == S_PAY)
                   || (state == S_TAIL);
    assign byte_stb = in_frame && mii_rxdv && phase;
    assign rx_byte  = {mii_rxd, lo_nib};
    assign len_now  = {len_hi, rx_byte};
    assign crc_nxt  = crc_byte(crc, rx_byte);
    assign crc_rev  = {<<{crc}};

    // Select the expected header byte for the current byte position.
    assign mac_b  = 8'(local_mac >> {6'd5 - byte_cnt, 3'b000});
    assign ip_b   = 8'(local_ip >> {6'd33 - byte_cnt, 3'b000});
    assign port_b = 8'(local_port >> {~byte_cnt[0], 3'b000});
    assign u_ok_n = ucast_ok && (rx_byte == mac_b);
    assign b_ok_n = ACCEPT_BCAST && bcast_ok && (rx_byte == 8'hFF);

    always_comb begin
        hdr_bad = 1'b0;
        unique case (1'b1)
            byte_cnt <= 6'd5:  hdr_bad = !(u_ok_n || b_ok_n);
            byte_cnt == 6'd12: hdr_bad = rx_byte != 8'h08;
            byte_cnt == 6'd13: hdr_bad = rx_byte != 8'h00;
            byte_cnt == 6'd14: hdr_bad = rx_byte != 8'h45;
            byte_cnt == 6'd23: hdr_bad = rx_byte != 8'h11;
            byte_cnt >= 6'd30 && byte_cnt <= 6'd33:
                hdr_bad = rx_byte != ip_b;
            byte_cnt == 6'd36 || byte_cnt == 6'd37:
                hdr_bad = rx_byte != port_b;
            byte_cnt == 6'd39:
                hdr_bad = (len_now < 16'd9) || (len_now > LEN_MAX);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pre_cnt     <= 2'd0;
            phase       <= 1'b0;
            lo_nib      <= 4'h0;
            byte_cnt    <= 6'd0;
            crc         <= 32'h0;
            ucast_ok    <= 1'b0;
            bcast_ok    <= 1'b0;
            sh_ip       <= 32'h0;
            sh_port     <= 16'h0;
            len_hi      <= 8'h0;
            pay_left    <= 11'd0;
            first       <= 1'b0;
            err         <= 1'b0;
            rx.dout       <= 8'h0;
            rx.dout_en    <= 1'b0;
            rx.dout_first <= 1'b0;
            rx.src_ip     <= 32'h0;
            rx.src_port   <= 16'h0;
            rx.rx_ok      <= 1'b0;
            rx.rx_err     <= 1'b0;
        end else begin
            rx.dout_en    <= 1'b0;
            rx.dout_first <= 1'b0;
            rx.rx_ok      <= 1'b0;
            rx.rx_err     <= 1'b0;
            if (mii_rxdv && !phase) lo_nib <= mii_rxd;
            if (in_frame && mii_rxdv) phase <= ~phase;
            if (byte_stb) crc <= crc_nxt;

            unique case (state)
                S_IDLE: if (mii_rxdv) begin
                    pre_cnt <= 2'd1;
                    state   <= (mii_rxd == 4'h5) ? S_PRE : S_DROP;
                end
                S_PRE: begin
                    if (!mii_rxdv) state <= S_IDLE;
                    else if (mii_rxer) state <= S_DROP;
                    else if (mii_rxd == 4'h5) begin
                        if (pre_cnt != 2'd3) pre_cnt <= pre_cnt + 2'd1;
                    end else if (mii_rxd == 4'hD && pre_cnt >= 2'd2) begin
                        state    <= S_HDR;
                        byte_cnt <= 6'd0;
                        crc      <= 32'hFFFFFFFF;
                        phase    <= 1'b0;
                        ucast_ok <= 1'b1;
                        bcast_ok <= 1'b1;
                        first    <= 1'b1;
                        err      <= 1'b0;
                    end else state <= S_DROP;
                end
                S_HDR: begin
                    if (!mii_rxdv) state <= S_IDLE;
                    else if (mii_rxer || (byte_stb && hdr_bad))
                        state <= S_DROP;
                    else if (byte_stb) begin
                        byte_cnt <= byte_cnt + 6'd1;
                        if (byte_cnt <= 6'd5) begin
                            ucast_ok <= u_ok_n;
                            bcast_ok <= b_ok_n;
                        end
                        if (byte_cnt >= 6'd26 && byte_cnt <= 6'd29)
                            sh_ip <= {sh_ip[23:0], rx_byte};
                        if (byte_cnt == 6'd34 || byte_cnt == 6'd35)
                            sh_port <= {sh_port[7:0], rx_byte};
                        if (byte_cnt == 6'd38) len_hi <= rx_byte;
                        if (byte_cnt == 6'd39)
                            pay_left <= len_now[10:0] - 11'd8;
                        if (byte_cnt == 6'd41) state <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (!mii_rxdv) begin
                        rx.rx_err <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        if (mii_rxer) err <= 1'b1;
                        if (byte_stb) begin
                            rx.dout       <= rx_byte;
                            rx.dout_en    <= 1'b1;
                            rx.dout_first <= first;
                            first         <= 1'b0;
                            if (first) begin
                                rx.src_ip   <= sh_ip;
                                rx.src_port <= sh_port;
                            end
                            pay_left <= pay_left - 11'd1;
                            if (pay_left == 11'd1) state <= S_TAIL;
                        end
                    end
                end
                S_TAIL: begin
                    if (!mii_rxdv) state <= S_END;
                    else if (mii_rxer) err <= 1'b1;
                end
                // Any nibble arriving in this cycle belongs to no frame.
                S_END: begin
                    if (crc_rev == RESIDUE && !phase && !err)
                        rx.rx_ok <= 1'b1;
                    else
                        rx.rx_err <= 1'b1;
                    state <= S_IDLE;
                end
                S_DROP: if (!mii_rxdv) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
